cache_controller_burst: RTL and testbench

Parametrised successor to the single-beat cache controller FSM.
- Sequences hit/miss handling for one cache port with multi-beat line transfers (write-back and refill of LINE_WORDS words) and per-beat memory handshake.
- Provides a selectable write-allocate / write-no-allocate policy.
- Sits between the core request interface and the memory-side bus adapter; datapath (tag/data arrays) lives outside and is steered by this block's enables and beat index.

---
 rtl/cache_ctrl_pkg.sv | 34 +++
 rtl/cache_beat_counter.sv | 34 +++
 rtl/cache_controller_burst.sv | 184 ++++++++++++++++++
 tb/tb_cache_controller_burst.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared types and helpers for the burst cache controller: FSM state encoding,
// request-type constants and the beat-index width rule.
package cache_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE           = 4'd0,
        COMPARE        = 4'd1,
        WRITE_BACK     = 4'd2,
        WRITE_ALLOCATE = 4'd3,
        REFILL_DONE    = 4'd4,
        WRITE_THROUGH  = 4'd5
    } state_t;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    // A single-word line still needs a 1-bit index port.
    function automatic int beat_width(input int line_words);
        return (line_words > 1) ? $clog2(line_words) : 1;
    endfunction

    function automatic string stateToString(input state_t s);
        case (s)
            IDLE:           return "IDLE";
            COMPARE:        return "COMPARE";
            WRITE_BACK:     return "WRITE_BACK";
            WRITE_ALLOCATE: return "WRITE_ALLOCATE";
            REFILL_DONE:    return "REFILL_DONE";
            WRITE_THROUGH:  return "WRITE_THROUGH";
            default:        return "UNKNOWN";
        endcase
    endfunction

endpackage

// File: rtl/cache_beat_counter.sv
// Beat index for line bursts: clears on request, advances on each accepted beat
// and wraps back to zero after the last word of the line.
module cache_beat_counter
    import cache_ctrl_pkg::*;
#(
    parameter  int LINE_WORDS = 4,
    localparam int BEAT_W     = beat_width(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [BEAT_W-1:0] idx,
    output logic              last
);

    localparam logic [BEAT_W-1:0] LAST_IDX = BEAT_W'(LINE_WORDS - 1);

    logic [BEAT_W-1:0] r_idx;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_idx <= '0;
        end else if (clr) begin
            r_idx <= '0;
        end else if (inc) begin
            r_idx <= last ? '0 : r_idx + BEAT_W'(1);
        end
    end

    assign idx  = r_idx;
    assign last = (r_idx == LAST_IDX);

endmodule

// File: rtl/cache_controller_burst.sv
// Cache controller FSM with multi-beat write-back/refill and selectable write policy.
// Define CACHE_PERF_CNT_EN to add saturating hit_cnt/miss_cnt outputs.
module cache_controller_burst #(
    parameter  int LINE_WORDS     = 4,
    parameter  int WRITE_ALLOCATE = 1,
    parameter  int CNT_W          = 32,
    localparam int BEAT_W         = cache_ctrl_pkg::beat_width(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_type,
    input  logic              hit,
    input  logic              dirty_bit,
    input  logic              ready_mem,
    output logic              req_ready,
    output logic              busy,
    output logic              read_en_mem,
    output logic              write_en_mem,
    output logic [BEAT_W-1:0] beat_idx,
    output logic              read_en_cache,
    output logic              write_en_cache,
    output logic              refill,
    output logic              done_cache
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
`endif
);
    // Package names are scoped explicitly: the WRITE_ALLOCATE parameter shares
    // its name with a state of the enum.
    import cache_ctrl_pkg::*;

    if (LINE_WORDS < 1 || (LINE_WORDS & (LINE_WORDS - 1)) != 0) begin : g_bad_line_words
        $error("LINE_WORDS must be a power of two >= 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be >= 1");
    end

    localparam logic NO_ALLOC = (WRITE_ALLOCATE == 0);

    cache_ctrl_pkg::state_t r_state;
    logic                   r_req_type;
    logic [BEAT_W-1:0]      w_idx;
    logic                   w_last;
    logic                   w_clr;
    logic                   w_inc;
    logic                   w_burst;

    assign w_burst = (r_state == cache_ctrl_pkg::WRITE_BACK) ||
                     (r_state == cache_ctrl_pkg::WRITE_ALLOCATE);
    assign w_clr   = (r_state == cache_ctrl_pkg::COMPARE);
    assign w_inc   = w_burst && ready_mem;

    cache_beat_counter #(
        .LINE_WORDS (LINE_WORDS)
    ) u_beat_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .inc  (w_inc),
        .idx  (w_idx),
        .last (w_last)
    );

    // Request type is only consumed after acceptance, so it needs no reset.
    always_ff @(posedge clk) begin
        if (r_state == cache_ctrl_pkg::IDLE && req_valid) begin
            r_req_type <= req_type;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= cache_ctrl_pkg::IDLE;
        end else begin
            case (r_state)
                cache_ctrl_pkg::IDLE: begin
                    if (req_valid) r_state <= cache_ctrl_pkg::COMPARE;
                end
                cache_ctrl_pkg::COMPARE: begin
                    if (hit)
                        r_state <= cache_ctrl_pkg::IDLE;
                    else if (r_req_type == cache_ctrl_pkg::REQ_WRITE && NO_ALLOC)
                        r_state <= cache_ctrl_pkg::WRITE_THROUGH;
                    else if (dirty_bit)
                        r_state <= cache_ctrl_pkg::WRITE_BACK;
                    else
                        r_state <= cache_ctrl_pkg::WRITE_ALLOCATE;
                end
                cache_ctrl_pkg::WRITE_BACK: begin
                    if (ready_mem && w_last) r_state <= cache_ctrl_pkg::WRITE_ALLOCATE;
                end
                cache_ctrl_pkg::WRITE_ALLOCATE: begin
                    if (ready_mem && w_last) r_state <= cache_ctrl_pkg::REFILL_DONE;
                end
                cache_ctrl_pkg::REFILL_DONE: begin
                    r_state <= cache_ctrl_pkg::COMPARE;
                end
                cache_ctrl_pkg::WRITE_THROUGH: begin
                    if (ready_mem) r_state <= cache_ctrl_pkg::IDLE;
                end
                default: r_state <= cache_ctrl_pkg::IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready      = 1'b0;
        busy           = 1'b1;
        read_en_mem    = 1'b0;
        write_en_mem   = 1'b0;
        beat_idx       = '0;
        read_en_cache  = 1'b0;
        write_en_cache = 1'b0;
        refill         = 1'b0;
        done_cache     = 1'b0;
        case (r_state)
            cache_ctrl_pkg::IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            cache_ctrl_pkg::COMPARE: begin
                read_en_cache  = 1'b1;
                done_cache     = hit;
                write_en_cache = hit && (r_req_type == cache_ctrl_pkg::REQ_WRITE);
            end
            cache_ctrl_pkg::WRITE_BACK: begin
                write_en_mem  = 1'b1;
                read_en_cache = 1'b1;
                beat_idx      = w_idx;
            end
            cache_ctrl_pkg::WRITE_ALLOCATE: begin
                read_en_mem    = 1'b1;
                beat_idx       = w_idx;
                write_en_cache = ready_mem;
            end
            cache_ctrl_pkg::REFILL_DONE: begin
                refill = 1'b1;
            end
            cache_ctrl_pkg::WRITE_THROUGH: begin
                write_en_mem = 1'b1;
                done_cache   = ready_mem;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

`ifdef CACHE_PERF_CNT_EN
    logic             r_relookup;
    logic [CNT_W-1:0] r_hit_cnt;
    logic [CNT_W-1:0] r_miss_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // The lookup that follows a refill is not a new request, so its hit is not counted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_relookup <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (r_state == cache_ctrl_pkg::REFILL_DONE)
                r_relookup <= 1'b1;
            else if (r_state == cache_ctrl_pkg::COMPARE)
                r_relookup <= 1'b0;
            if (r_state == cache_ctrl_pkg::COMPARE) begin
                if (hit && !r_relookup) r_hit_cnt <= sat_inc(r_hit_cnt);
                if (!hit) r_miss_cnt <= sat_inc(r_miss_cnt);
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_cache_controller_burst.sv
// Directed bench for cache_controller_burst: write-allocate instance (a) and
// write-no-allocate instance (b); counter test compiled with CACHE_PERF_CNT_EN.
module tb_cache_controller_burst;

    logic clk = 1'b0;
    logic rst;
    logic req_valid, req_type, hit, dirty_bit, ready_mem;

    logic       a_req_ready, a_busy, a_rd_mem, a_wr_mem, a_rd_c, a_wr_c, a_refill, a_done;
    logic       b_req_ready, b_busy, b_rd_mem, b_wr_mem, b_rd_c, b_wr_c, b_refill, b_done;
    logic [1:0] a_beat, b_beat;
`ifdef CACHE_PERF_CNT_EN
    logic [31:0] a_hit_cnt, a_miss_cnt, b_hit_cnt, b_miss_cnt;
`endif

    // {req_ready, busy, read_en_mem, write_en_mem, read_en_cache, write_en_cache, refill, done_cache}
    wire [7:0] a_out = {a_req_ready, a_busy, a_rd_mem, a_wr_mem, a_rd_c, a_wr_c, a_refill, a_done};
    wire [7:0] b_out = {b_req_ready, b_busy, b_rd_mem, b_wr_mem, b_rd_c, b_wr_c, b_refill, b_done};

    localparam logic [7:0] O_IDLE   = 8'b1000_0000;
    localparam logic [7:0] O_RHIT   = 8'b0100_1001;
    localparam logic [7:0] O_WHIT   = 8'b0100_1101;
    localparam logic [7:0] O_MISS   = 8'b0100_1000;
    localparam logic [7:0] O_WB     = 8'b0101_1000;
    localparam logic [7:0] O_WA     = 8'b0110_0100;
    localparam logic [7:0] O_REFILL = 8'b0100_0010;
    localparam logic [7:0] O_WT     = 8'b0101_0000;
    localparam logic [7:0] O_WTDONE = 8'b0101_0001;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cache_controller_burst #(.LINE_WORDS(4), .WRITE_ALLOCATE(1), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_type(req_type), .hit(hit),
        .dirty_bit(dirty_bit), .ready_mem(ready_mem), .req_ready(a_req_ready), .busy(a_busy),
        .read_en_mem(a_rd_mem), .write_en_mem(a_wr_mem), .beat_idx(a_beat),
        .read_en_cache(a_rd_c), .write_en_cache(a_wr_c), .refill(a_refill), .done_cache(a_done)
`ifdef CACHE_PERF_CNT_EN
        , .hit_cnt(a_hit_cnt), .miss_cnt(a_miss_cnt)
`endif
    );

    cache_controller_burst #(.LINE_WORDS(4), .WRITE_ALLOCATE(0), .CNT_W(32)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_type(req_type), .hit(hit),
        .dirty_bit(dirty_bit), .ready_mem(ready_mem), .req_ready(b_req_ready), .busy(b_busy),
        .read_en_mem(b_rd_mem), .write_en_mem(b_wr_mem), .beat_idx(b_beat),
        .read_en_cache(b_rd_c), .write_en_cache(b_wr_c), .refill(b_refill), .done_cache(b_done)
`ifdef CACHE_PERF_CNT_EN
        , .hit_cnt(b_hit_cnt), .miss_cnt(b_miss_cnt)
`endif
    );

    // Drive one cycle's inputs after the falling edge and settle before sampling.
    task automatic drive(input logic rv, input logic rt, input logic h, input logic d, input logic rdy);
        @(negedge clk);
        req_valid = rv; req_type = rt; hit = h; dirty_bit = d; ready_mem = rdy;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0; req_type = 1'b0; hit = 1'b0; dirty_bit = 1'b0; ready_mem = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (a_out !== O_IDLE) begin n_err++; $display("FAIL reset_out_a: got %b expected %b", a_out, O_IDLE); end
        n_cmp++;
        if (a_beat !== 2'd0) begin n_err++; $display("FAIL reset_beat_a: got %0d expected 0", a_beat); end
        n_cmp++;
        if (b_out !== O_IDLE) begin n_err++; $display("FAIL reset_out_b: got %b expected %b", b_out, O_IDLE); end
    endtask

    task automatic test_read_hit();
        do_reset();
        drive(1, 0, 0, 0, 0);
        n_cmp++;
        if (a_out !== O_IDLE) begin n_err++; $display("FAIL rhit_accept: got %b expected %b", a_out, O_IDLE); end
        drive(0, 0, 1, 0, 0);
        n_cmp++;
        if (a_out !== O_RHIT) begin n_err++; $display("FAIL rhit_compare: got %b expected %b", a_out, O_RHIT); end
        drive(0, 0, 0, 0, 0);
        n_cmp++;
        if (a_out !== O_IDLE) begin n_err++; $display("FAIL rhit_idle: got %b expected %b", a_out, O_IDLE); end
    endtask

    task automatic test_write_miss_clean();
        do_reset();
        drive(1, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 1);
        n_cmp++;
        if (a_out !== O_MISS) begin n_err++; $display("FAIL wmiss_compare: got %b expected %b", a_out, O_MISS); end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 1);
            n_cmp++;
            if (a_out !== O_WA || a_beat !== 2'(i)) begin
                n_err++;
                $display("FAIL wmiss_alloc_beat%0d: got %b idx %0d expected %b idx %0d", i, a_out, a_beat, O_WA, i);
            end
        end
        drive(0, 0, 0, 0, 1);
        n_cmp++;
        if (a_out !== O_REFILL) begin n_err++; $display("FAIL wmiss_refill: got %b expected %b", a_out, O_REFILL); end
        drive(0, 0, 1, 0, 1);
        n_cmp++;
        if (a_out !== O_WHIT) begin n_err++; $display("FAIL wmiss_relookup: got %b expected %b", a_out, O_WHIT); end
        drive(0, 0, 0, 0, 0);
        n_cmp++;
        if (a_out !== O_IDLE) begin n_err++; $display("FAIL wmiss_idle: got %b expected %b", a_out, O_IDLE); end
    endtask

    task automatic test_read_miss_dirty();
        logic       wb_rdy [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [1:0] wb_idx [6] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3};
        do_reset();
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 1);
        n_cmp++;
        if (a_out !== O_MISS) begin n_err++; $display("FAIL rdirty_compare: got %b expected %b", a_out, O_MISS); end
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 0, wb_rdy[i]);
            n_cmp++;
            if (a_out !== O_WB || a_beat !== wb_idx[i]) begin
                n_err++;
                $display("FAIL rdirty_wb_step%0d: got %b idx %0d expected %b idx %0d", i, a_out, a_beat, O_WB, wb_idx[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 1);
            n_cmp++;
            if (a_out !== O_WA || a_beat !== 2'(i)) begin
                n_err++;
                $display("FAIL rdirty_alloc_beat%0d: got %b idx %0d expected %b idx %0d", i, a_out, a_beat, O_WA, i);
            end
        end
        drive(0, 0, 0, 0, 1);
        n_cmp++;
        if (a_out !== O_REFILL) begin n_err++; $display("FAIL rdirty_refill: got %b expected %b", a_out, O_REFILL); end
        drive(0, 0, 1, 0, 1);
        n_cmp++;
        if (a_out !== O_RHIT) begin n_err++; $display("FAIL rdirty_relookup: got %b expected %b", a_out, O_RHIT); end
    endtask

    task automatic test_write_through();
        do_reset();
        drive(1, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        n_cmp++;
        if (b_out !== O_MISS) begin n_err++; $display("FAIL wt_compare: got %b expected %b", b_out, O_MISS); end
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0);
            n_cmp++;
            if (b_out !== O_WT || b_beat !== 2'd0) begin
                n_err++;
                $display("FAIL wt_stall%0d: got %b idx %0d expected %b idx 0", i, b_out, b_beat, O_WT);
            end
        end
        drive(0, 0, 0, 0, 1);
        n_cmp++;
        if (b_out !== O_WTDONE) begin n_err++; $display("FAIL wt_done: got %b expected %b", b_out, O_WTDONE); end
        drive(0, 0, 0, 0, 0);
        n_cmp++;
        if (b_out !== O_IDLE) begin n_err++; $display("FAIL wt_idle: got %b expected %b", b_out, O_IDLE); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        @(negedge clk);
        rst = 1'b0; ready_mem = 1'b1;
        #1;
        n_cmp++;
        if (a_out !== O_WB || a_beat !== 2'd2) begin
            n_err++;
            $display("FAIL midrst_beat2: got %b idx %0d expected %b idx 2", a_out, a_beat, O_WB);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (a_out !== O_IDLE || a_beat !== 2'd0) begin
            n_err++;
            $display("FAIL midrst_idle: got %b idx %0d expected %b idx 0", a_out, a_beat, O_IDLE);
        end
        drive(0, 0, 0, 0, 1);
        n_cmp++;
        if (a_out !== O_IDLE) begin n_err++; $display("FAIL midrst_stay_idle: got %b expected %b", a_out, O_IDLE); end
    endtask

    // Type is latched on accept: the COMPARE cycle sees the opposite req_type on the pins.
    task automatic test_back_to_back();
        do_reset();
        drive(1, 1, 0, 0, 0);
        drive(1, 0, 1, 0, 0);
        n_cmp++;
        if (a_out !== O_WHIT) begin n_err++; $display("FAIL b2b_write_hit: got %b expected %b", a_out, O_WHIT); end
        drive(1, 0, 0, 0, 0);
        n_cmp++;
        if (a_out !== O_IDLE) begin n_err++; $display("FAIL b2b_idle: got %b expected %b", a_out, O_IDLE); end
        drive(0, 1, 1, 0, 0);
        n_cmp++;
        if (a_out !== O_RHIT) begin n_err++; $display("FAIL b2b_read_hit: got %b expected %b", a_out, O_RHIT); end
    endtask

`ifdef CACHE_PERF_CNT_EN
    task automatic test_perf_cnt();
        do_reset();
        n_cmp++;
        if (b_hit_cnt !== 32'd0 || b_miss_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL perf_reset: got hit %0d miss %0d expected 0 0", b_hit_cnt, b_miss_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0);
            drive(0, 0, 1, 0, 0);
        end
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 1);
        drive(0, 0, 1, 0, 1);
        drive(1, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        n_cmp++;
        if (b_hit_cnt !== 32'd3 || b_miss_cnt !== 32'd2) begin
            n_err++;
            $display("FAIL perf_counts: got hit %0d miss %0d expected 3 2", b_hit_cnt, b_miss_cnt);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_type = 1'b0; hit = 1'b0; dirty_bit = 1'b0; ready_mem = 1'b0;
        test_reset();
        test_read_hit();
        test_write_miss_clean();
        test_read_miss_dirty();
        test_write_through();
        test_reset_mid_burst();
        test_back_to_back();
`ifdef CACHE_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
